// File: rtl/rr_arbiter16.sv
// rtl/rr_arbiter16.sv - 16-way round-robin burst arbiter for one shared word channel
//
// Grants one of 16 requesters the shared channel.
// A grant is held for up to MAX_BEATS accepted beats, then the arbiter rotates.
// Ports:
//   clk, reset_n  clock (rising edge) and asynchronous active-low reset
//   req[15:0]     per-requester request
//   out_ready     consumer accepts the current word this cycle
//   sel[3:0]      mux select = index of the granted requester (registered)
//   grant[15:0]   one-hot grant, zero when idle (registered)
//   out_valid     granted word valid on the shared channel (busy & req[sel])
//   busy          a grant is active (registered)

module rr_arbiter16 #(
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] req,
  input  logic        out_ready,
  output logic [3:0]  sel,
  output logic [15:0] grant,
  output logic        out_valid,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [7:0] MAX_B = 8'(MAX_BEATS);

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [15:0] grant_q, grant_d;
  logic [7:0]  beat_q, beat_d;

  logic        beat_ok;
  logic        grant_end;
  logic [3:0]  search_ptr;
  logic [3:0]  win;

  assign beat_ok   = (state_q == BUSY) & req[sel_q] & out_ready;
  // Early release (request dropped) or burst quota reached on this beat.
  assign grant_end = (state_q == BUSY) &
                     (~req[sel_q] | (beat_ok & ((beat_q + 8'd1) == MAX_B)));
  // Ending a grant re-arbitrates in the same edge from the slot after the owner.
  assign search_ptr = grant_end ? (sel_q + 4'd1) : ptr_q;

  // Scan downward so the candidate closest to search_ptr is written last and wins.
  always_comb begin
    win = search_ptr;
    for (int k = 15; k >= 0; k--) begin
      if (req[search_ptr + 4'(k)]) begin
        win = search_ptr + 4'(k);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= 4'h0;
      ptr_q   <= 4'h0;
      grant_q <= 16'h0000;
      beat_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          sel_d   = win;
          grant_d = 16'h0001 << win;
          beat_d  = 8'h00;
        end
      end
      BUSY: begin
        if (grant_end) begin
          ptr_d  = sel_q + 4'd1;
          beat_d = 8'h00;
          if (|req) begin
            sel_d   = win;
            grant_d = 16'h0001 << win;
          end else begin
            state_d = IDLE;
            grant_d = 16'h0000;
          end
        end else if (beat_ok) begin
          beat_d = beat_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state_q == BUSY);
    grant     = grant_q;
    sel       = sel_q;
    out_valid = (state_q == BUSY) & req[sel_q];
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb/tb_rr_arbiter16.sv - scoreboard bench for rr_arbiter16 against a behavioural model

module tb_rr_arbiter16;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] req;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        out_valid;
  logic        busy;

  rr_arbiter16 #(.MAX_BEATS(MAXB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .out_ready (out_ready),
    .sel       (sel),
    .grant     (grant),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        busy;
    logic        valid;
    logic        chk_sel;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Model: owner index (-1 when idle), rotation pointer, beats accepted in the current grant.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;

  function automatic int m_win(input logic [15:0] r, input int p);
    for (int k = 0; k < 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  task automatic m_step(input logic [15:0] r, input logic rdy, input logic rst);
    bit accepted;
    bit done;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_beats = 0;
    end else if (m_owner < 0) begin
      if (r != 16'h0) begin
        m_owner = m_win(r, m_ptr);
        m_beats = 0;
      end
    end else begin
      accepted = r[m_owner] && rdy;
      done     = !r[m_owner] || (accepted && (m_beats + 1 == MAXB));
      if (done) begin
        m_ptr   = (m_owner + 1) % 16;
        m_beats = 0;
        m_owner = (r != 16'h0) ? m_win(r, m_ptr) : -1;
      end else if (accepted) begin
        m_beats++;
      end
    end
  endtask

  task automatic cycle(input logic [15:0] r, input logic rdy, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    req       = r;
    out_ready = rdy;
    reset_n   = ~rst;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_beats = 0;
    end
    e.busy    = (m_owner >= 0);
    e.grant   = e.busy ? (16'h0001 << m_owner) : 16'h0000;
    e.sel     = e.busy ? 4'(m_owner) : 4'h0;
    e.valid   = e.busy && r[m_owner];
    e.chk_sel = e.busy || rst;
    exp_q.push_back(e);
    m_step(r, rdy, rst);
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (grant !== e.grant || busy !== e.busy || out_valid !== e.valid ||
          (e.chk_sel && sel !== e.sel)) begin
        miscompares++;
        $display("FAIL outputs cyc%0d: got grant=%h sel=%0d busy=%b valid=%b, want grant=%h sel=%0d busy=%b valid=%b",
                 cyc, grant, sel, busy, out_valid, e.grant, e.sel, e.busy, e.valid);
      end
    end
  end

  initial begin
    logic [15:0] r;
    logic        rdy;
    logic        rst;
    reset_n   = 1'b0;
    req       = 16'h0000;
    out_ready = 1'b0;
    r         = 16'h0000;

    // Reset with all requests high, then release.
    cycle(16'hFFFF, 1'b1, 1'b1);
    cycle(16'hFFFF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(16'hFFFF, 1'b1, 1'b0);

    // Single requester 5: back-to-back regrant.
    for (int i = 0; i < 14; i++) cycle(16'h0020, 1'b1, 1'b0);

    // 15 -> 0 wrap.
    for (int i = 0; i < 20; i++) cycle(16'h8001, 1'b1, 1'b0);

    // Requester 3 stalled by out_ready low, then released.
    cycle(16'h0000, 1'b1, 1'b0);
    cycle(16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 11; i++) cycle(16'h0008, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)  cycle(16'h0008, 1'b1, 1'b0);

    // Requester 3 drops after two beats while 7 waits.
    cycle(16'h0000, 1'b1, 1'b0);
    cycle(16'h0000, 1'b1, 1'b0);
    cycle(16'h0008, 1'b1, 1'b0);
    cycle(16'h0088, 1'b1, 1'b0);
    cycle(16'h0088, 1'b1, 1'b0);
    cycle(16'h0080, 1'b1, 1'b0);
    cycle(16'h0080, 1'b1, 1'b0);

    // Asynchronous reset mid-burst, then pointer restart at 0.
    cycle(16'h0081, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) cycle(16'h0081, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: r = 16'($urandom);
        1: r = 16'($urandom & $urandom & $urandom);
        2: r = 16'h0001 << $urandom_range(0, 15);
        default: r = r;
      endcase
      rdy = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      cycle(r, rdy, rst);
    end

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
